// File: rtl/datamem_sized.sv
// Byte/half/word data memory for the MEM stage, with byte-lane stores, sign/zero-extended loads,
// a configurable-latency read pipeline and misaligned-access rejection.
module datamem_sized #(
  parameter int    AW        = 10,
  parameter int    READ_LAT  = 1,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        misalign
);

  localparam int DEPTH = 1 << AW;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          aligned, wr_en, rd_en, misalign_d;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic          unused_addr;

  assign idx         = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] sz,
                                         input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*lane +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   extend = {{24{~uns & b[7]}}, b};
      2'b01:   extend = {{16{~uns & h[15]}}, h};
      default: extend = w;
    endcase
  endfunction

  // Replicating the store data across lanes lets the byte enables alone pick the target lane.
  always_comb begin
    aligned = 1'b1;
    be      = 4'b1111;
    wlane   = wdata;
    case (size)
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wlane = {4{wdata[7:0]}};
      end
      2'b01: begin
        aligned = ~addr[0];
        be      = addr[1] ? 4'b1100 : 4'b0011;
        wlane   = {2{wdata[15:0]}};
      end
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  assign wr_en      = memwrite & aligned;
  assign rd_en      = memread & ~memwrite & aligned;
  assign misalign_d = (memread | memwrite) & ~aligned;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  logic [31:0] src_word;
  logic        src_vld, src_uns;
  logic [1:0]  src_sz, src_lane;

  generate
    if (READ_LAT <= 1) begin : g_direct
      assign src_word = mem[idx];
      assign src_vld  = rd_en;
      assign src_sz   = size;
      assign src_lane = addr[1:0];
      assign src_uns  = unsigned_ld;
    end else begin : g_pipe
      localparam int PL = READ_LAT - 1;
      logic [31:0] word_p [PL];
      logic [1:0]  sz_p   [PL];
      logic [1:0]  lane_p [PL];
      logic        uns_p  [PL];
      logic        vld_p  [PL];

      // Stage 0: registered array read; later stages only delay the raw word and its controls.
      always_ff @(posedge clk) begin
        word_p[0] <= mem[idx];
        sz_p[0]   <= size;
        lane_p[0] <= addr[1:0];
        uns_p[0]  <= unsigned_ld;
        for (int k = 1; k < PL; k++) begin
          word_p[k] <= word_p[k-1];
          sz_p[k]   <= sz_p[k-1];
          lane_p[k] <= lane_p[k-1];
          uns_p[k]  <= uns_p[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < PL; k++) vld_p[k] <= 1'b0;
        end else begin
          vld_p[0] <= rd_en;
          for (int k = 1; k < PL; k++) vld_p[k] <= vld_p[k-1];
        end
      end

      assign src_word = word_p[PL-1];
      assign src_vld  = vld_p[PL-1];
      assign src_sz   = sz_p[PL-1];
      assign src_lane = lane_p[PL-1];
      assign src_uns  = uns_p[PL-1];
    end
  endgenerate

  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, misalign_q;

  always_comb begin
    rdata_d = rdata_q;
    if (src_vld) rdata_d = extend(src_word, src_sz, src_lane, src_uns);
  end

  // Output stage: lane select/extension feeds this register; rdata holds between loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      rvalid_q   <= src_vld;
      misalign_q <= misalign_d;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_datamem_sized.sv
// Scoreboard bench for datamem_sized: the driver queues expected loads/misalign pulses with
// their due cycle, and a negedge monitor compares every cycle against those queues.
module tb_datamem_sized;
  localparam int AW  = 6;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memread = 1'b1, memwrite = 1'b0, unsigned_ld = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        rvalid, misalign;

  datamem_sized #(.AW(AW), .READ_LAT(LAT), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .rdata(rdata),
    .rvalid(rvalid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t q[$];
  int   mq[$];
  int   cyc = 0;
  logic rst_at_edge = 1'b1;
  int   checks = 0, errors = 0;
  logic [31:0] last_rdata = '0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  // Monitor
  initial begin
    logic exp_v, exp_m;
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        if (rst_at_edge) begin
          chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
          chk("rst_rdata", rdata, 32'd0);
          chk("rst_misalign", {31'b0, misalign}, 32'd0);
          last_rdata = '0;
        end else begin
          exp_v = (q.size() > 0) && (q[0].due == cyc);
          chk("rvalid", {31'b0, rvalid}, {31'b0, exp_v});
          if (exp_v) begin
            chk("rdata", rdata, q[0].data);
            last_rdata = q[0].data;
            void'(q.pop_front());
          end else begin
            chk("rdata_hold", rdata, last_rdata);
          end
          while (q.size() > 0 && q[0].due < cyc) begin
            chk("load_missing", 32'd0, q[0].data);
            void'(q.pop_front());
          end
          exp_m = (mq.size() > 0) && (mq[0] == cyc);
          chk("misalign", {31'b0, misalign}, {31'b0, exp_m});
          if (exp_m) void'(mq.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    memread = rd; memwrite = wr; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] exp);
    q.push_back('{data: exp, due: cyc + LAT});
    drive(1'b1, 1'b0, sz, uns, a, 32'd0);
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    drive(1'b0, 1'b1, sz, 1'b0, a, wd);
  endtask

  task automatic bad(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] a);
    mq.push_back(cyc + 1);
    drive(rd, wr, sz, 1'b0, a, 32'h1234_5678);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
    rst = 1'b1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    // Reset release and first-load latency
    store(2'b10, 32'h0, 32'h0000_1234);
    load(2'b10, 1'b0, 32'h0, 32'h0000_1234);
    idle(4);
    // Sign/zero extension
    store(2'b10, 32'h10, 32'h8000_00F1);
    load(2'b00, 1'b0, 32'h10, 32'hFFFF_FFF1);
    load(2'b00, 1'b1, 32'h10, 32'h0000_00F1);
    load(2'b01, 1'b0, 32'h12, 32'hFFFF_8000);
    load(2'b01, 1'b1, 32'h12, 32'h0000_8000);
    load(2'b00, 1'b0, 32'h13, 32'hFFFF_FF80);
    load(2'b10, 1'b0, 32'h10, 32'h8000_00F1);
    load(2'b11, 1'b1, 32'h10, 32'h8000_00F1);
    // Lane-selective stores
    store(2'b10, 32'h20, 32'h1122_3344);
    store(2'b00, 32'h21, 32'h0000_00AA);
    store(2'b01, 32'h22, 32'h0000_BEEF);
    load(2'b10, 1'b0, 32'h20, 32'hBEEF_AA44);
    load(2'b00, 1'b1, 32'h21, 32'h0000_00AA);
    idle(4);
    // Misaligned accesses
    store(2'b10, 32'h40, 32'hDEAD_BEEF);
    bad(1'b1, 1'b0, 2'b10, 32'h41);
    bad(1'b0, 1'b1, 2'b01, 32'h43);
    bad(1'b1, 1'b0, 2'b01, 32'h41);
    load(2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF);
    load(2'b00, 1'b0, 32'h43, 32'hFFFF_FFDE);
    idle(4);
    // Back-to-back burst, then a burst cut short by reset
    store(2'b10, 32'h0, 32'h0000_00A0);
    store(2'b10, 32'h4, 32'h0000_00A1);
    store(2'b10, 32'h8, 32'h0000_00A2);
    store(2'b10, 32'hC, 32'h0000_00A3);
    load(2'b10, 1'b0, 32'h0, 32'h0000_00A0);
    load(2'b10, 1'b0, 32'h4, 32'h0000_00A1);
    load(2'b10, 1'b0, 32'h8, 32'h0000_00A2);
    load(2'b10, 1'b0, 32'hC, 32'h0000_00A3);
    idle(4);
    load(2'b10, 1'b0, 32'h0, 32'h0000_00A0);
    load(2'b10, 1'b0, 32'h4, 32'h0000_00A1);
    do_reset();
    idle(5);
    // Address wrap and simultaneous read/write
    store(2'b10, 32'h100, 32'h5A5A_5A5A);
    load(2'b10, 1'b0, 32'h0, 32'h5A5A_5A5A);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h0000_0077);
    load(2'b10, 1'b0, 32'h8, 32'h0000_0077);
    idle(LAT + 3);
    chk("drain", q.size() + mq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
